// File: rtl/icache_fill_if.sv
// Fetch, cache-array, DRAM and invalidate/fence signals of the I-cache fill controller.
// master = the controller, slave = the surrounding cache/memory/core.
interface icache_fill_if #(
  parameter int W_INDEX = 5
);
  logic               i_req_valid;
  logic [31:0]        i_req_addr;
  logic               o_req_ready;
  logic               o_rsp_valid;
  logic [31:0]        o_rsp_inst;
  logic [27:0]        o_cache_raddr;
  logic               i_cache_hit;
  logic [127:0]       i_cache_rdata;
  logic               o_cache_we;
  logic [27:0]        o_cache_waddr;
  logic [127:0]       o_cache_wdata;
  logic               o_cache_inv;
  logic [W_INDEX-1:0] o_cache_inv_index;
  logic               o_cache_flush;
  logic               o_dram_req;
  logic [31:0]        o_dram_addr;
  logic               i_dram_ack;
  logic               i_dram_rvalid;
  logic [127:0]       i_dram_rdata;
  logic               i_inv_valid;
  logic [31:0]        i_inv_addr;
  logic               o_inv_ready;
  logic               i_fence;
  logic               o_fence_done;
  logic               o_busy;

  modport master (
    input  i_req_valid, i_req_addr, i_cache_hit, i_cache_rdata,
           i_dram_ack, i_dram_rvalid, i_dram_rdata, i_inv_valid, i_inv_addr, i_fence,
    output o_req_ready, o_rsp_valid, o_rsp_inst, o_cache_raddr, o_cache_we, o_cache_waddr,
           o_cache_wdata, o_cache_inv, o_cache_inv_index, o_cache_flush, o_dram_req,
           o_dram_addr, o_inv_ready, o_fence_done, o_busy
  );

  modport slave (
    output i_req_valid, i_req_addr, i_cache_hit, i_cache_rdata,
           i_dram_ack, i_dram_rvalid, i_dram_rdata, i_inv_valid, i_inv_addr, i_fence,
    input  o_req_ready, o_rsp_valid, o_rsp_inst, o_cache_raddr, o_cache_we, o_cache_waddr,
           o_cache_wdata, o_cache_inv, o_cache_inv_index, o_cache_flush, o_dram_req,
           o_dram_addr, o_inv_ready, o_fence_done, o_busy
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped I-cache sequencer: 1-cycle hits, single-line DRAM refill, queued
// per-index invalidates and fence.i flush, with refetch when a refill went stale.
module icache_fill_ctrl #(
  parameter bit ENABLED   = 1'b1,
  parameter int N_ENTRY   = 32,
  parameter int INV_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  icache_fill_if.master bus
);
  localparam int W_INDEX = $clog2(N_ENTRY);
  localparam int W_PTR   = $clog2(INV_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

  state_t              state, state_nxt;
  logic [31:2]         r_addr;
  logic [127:0]        r_data;
  logic                r_stale, fence_pend;
  logic                r_hit_pend;
  logic [31:0]         r_hit_inst;
  logic [W_INDEX-1:0]  inv_q [INV_DEPTH];
  logic [W_PTR-1:0]    wr_ptr, rd_ptr;
  logic [W_PTR:0]      inv_cnt;

  logic [3:0][31:0]    hit_words, fill_words;
  logic inv_full, inv_empty, inv_push;
  logic do_flush, do_pop, can_acc, accept, hit_use, in_flight, stale_evt;

  assign hit_words  = bus.i_cache_rdata;
  assign fill_words = r_data;

  assign inv_full  = (inv_cnt == (W_PTR+1)'(INV_DEPTH));
  assign inv_empty = (inv_cnt == '0);
  assign inv_push  = bus.i_inv_valid && !inv_full;

  assign do_flush  = (state == IDLE) && fence_pend;
  assign do_pop    = (state == IDLE) && !fence_pend && !inv_empty;
  assign can_acc   = (state == IDLE) && !fence_pend && inv_empty;
  assign accept    = can_acc && bus.i_req_valid;
  assign hit_use   = accept && bus.i_cache_hit && ENABLED;
  assign in_flight = (state == REQ) || (state == WAIT);
  // A line matching the in-flight refill, or any fence, makes the returning data untrustworthy.
  assign stale_evt = in_flight &&
                     ((inv_push && (bus.i_inv_addr[31:4] == r_addr[31:4])) || bus.i_fence);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_stale    <= 1'b0;
      fence_pend <= 1'b0;
      r_hit_pend <= 1'b0;
      r_hit_inst <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inv_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      r_hit_pend <= hit_use;
      if (hit_use) r_hit_inst <= hit_words[bus.i_req_addr[3:2]];
      if (accept) r_addr <= bus.i_req_addr[31:2];
      if (state == WAIT && bus.i_dram_rvalid) r_data <= bus.i_dram_rdata;

      if (stale_evt)          r_stale <= 1'b1;
      else if (state == FILL) r_stale <= 1'b0;

      if (bus.i_fence)   fence_pend <= 1'b1;
      else if (do_flush) fence_pend <= 1'b0;

      // The flush covers every entry, so queued (and same-cycle) invalidates are dropped.
      if (do_flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        inv_cnt <= '0;
      end else begin
        if (inv_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
        case ({inv_push, do_pop})
          2'b10:   inv_cnt <= inv_cnt + 1'b1;
          2'b01:   inv_cnt <= inv_cnt - 1'b1;
          default: inv_cnt <= inv_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (inv_push) inv_q[wr_ptr] <= bus.i_inv_addr[4 +: W_INDEX];
  end

  // While RST is held the outputs present their reset values regardless of state.
  always_comb begin
    state_nxt             = state;
    bus.o_req_ready       = 1'b0;
    bus.o_rsp_valid       = 1'b0;
    bus.o_rsp_inst        = '0;
    bus.o_cache_raddr     = '0;
    bus.o_cache_we        = 1'b0;
    bus.o_cache_waddr     = '0;
    bus.o_cache_wdata     = '0;
    bus.o_cache_inv       = 1'b0;
    bus.o_cache_inv_index = '0;
    bus.o_cache_flush     = 1'b0;
    bus.o_dram_req        = 1'b0;
    bus.o_dram_addr       = '0;
    bus.o_inv_ready       = 1'b1;
    bus.o_fence_done      = 1'b0;
    bus.o_busy            = 1'b0;
    if (!RST) begin
      bus.o_inv_ready = !inv_full;
      bus.o_busy      = (state != IDLE) || !inv_empty || fence_pend;
      bus.o_rsp_valid = r_hit_pend;
      bus.o_rsp_inst  = r_hit_inst;
      case (state)
        IDLE: begin
          bus.o_cache_flush = fence_pend;
          bus.o_fence_done  = fence_pend;
          bus.o_cache_inv   = do_pop;
          if (do_pop) bus.o_cache_inv_index = inv_q[rd_ptr];
          bus.o_req_ready   = can_acc;
          if (can_acc) bus.o_cache_raddr = bus.i_req_addr[31:4];
          if (accept && !hit_use) state_nxt = REQ;
        end
        REQ: begin
          bus.o_dram_req  = 1'b1;
          bus.o_dram_addr = {r_addr[31:4], 4'b0};
          if (bus.i_dram_ack) state_nxt = WAIT;
        end
        WAIT: begin
          if (bus.i_dram_rvalid) state_nxt = FILL;
        end
        FILL: begin
          if (r_stale) begin
            state_nxt = REQ;
          end else begin
            bus.o_cache_we    = ENABLED;
            bus.o_cache_waddr = r_addr[31:4];
            bus.o_cache_wdata = r_data;
            bus.o_rsp_valid   = 1'b1;
            bus.o_rsp_inst    = fill_words[r_addr[3:2]];
            state_nxt         = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: one ENABLED instance for hit/miss/stale/fence/FIFO
// scenarios and one ENABLED=0 instance for bypass and mid-refill reset.
module tb_icache_fill_ctrl;
  logic CLK = 1'b0;
  logic RST, RST_D;
  int   n_chk = 0;
  int   n_fail = 0;

  localparam logic [127:0] LINE_H = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] LINE_D = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444;
  localparam logic [127:0] LINE_E = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  always #5 CLK = ~CLK;

  icache_fill_if #(.W_INDEX(5)) b ();
  icache_fill_if #(.W_INDEX(5)) d ();

  icache_fill_ctrl #(.ENABLED(1'b1), .N_ENTRY(32), .INV_DEPTH(4)) u_en (
    .CLK(CLK), .RST(RST), .bus(b));
  icache_fill_ctrl #(.ENABLED(1'b0), .N_ENTRY(32), .INV_DEPTH(4)) u_dis (
    .CLK(CLK), .RST(RST_D), .bus(d));

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    b.i_req_valid = 0; b.i_req_addr = '0; b.i_cache_hit = 0; b.i_cache_rdata = '0;
    b.i_dram_ack = 0; b.i_dram_rvalid = 0; b.i_dram_rdata = '0;
    b.i_inv_valid = 0; b.i_inv_addr = '0; b.i_fence = 0;
    d.i_req_valid = 0; d.i_req_addr = '0; d.i_cache_hit = 0; d.i_cache_rdata = '0;
    d.i_dram_ack = 0; d.i_dram_rvalid = 0; d.i_dram_rdata = '0;
    d.i_inv_valid = 0; d.i_inv_addr = '0; d.i_fence = 0;
    RST = 1; RST_D = 1;
    cyc(); cyc();
    settle();
    check("rst_req_ready", b.o_req_ready, 0);
    check("rst_inv_ready", b.o_inv_ready, 1);
    check("rst_busy", b.o_busy, 0);
    check("rst_rsp_valid", b.o_rsp_valid, 0);
    check("rst_dram_req", b.o_dram_req, 0);
    RST = 0; RST_D = 0;
    settle();
    check("post_rst_req_ready", b.o_req_ready, 1);
    check("post_rst_busy", b.o_busy, 0);
    cyc();

    // hit on line 0x1000, word 2
    b.i_req_valid = 1; b.i_req_addr = 32'h1008; b.i_cache_hit = 1; b.i_cache_rdata = LINE_H;
    settle();
    check("hit_ready", b.o_req_ready, 1);
    check("hit_raddr", b.o_cache_raddr, 28'h100);
    cyc();
    b.i_req_valid = 0; b.i_cache_hit = 0;
    settle();
    check("hit_rsp_valid", b.o_rsp_valid, 1);
    check("hit_rsp_inst", b.o_rsp_inst, 32'h3333_3333);
    check("hit_dram_req", b.o_dram_req, 0);
    cyc(); settle();
    check("hit_rsp_pulse", b.o_rsp_valid, 0);

    // miss with 3-cycle ack stall
    b.i_req_valid = 1; b.i_req_addr = 32'h2004;
    settle();
    check("miss_ready", b.o_req_ready, 1);
    cyc();
    b.i_req_valid = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("miss_dram_req", b.o_dram_req, 1);
      check("miss_dram_addr", b.o_dram_addr, 32'h2000);
      cyc();
    end
    b.i_dram_ack = 1;
    settle();
    check("miss_req_at_ack", b.o_dram_req, 1);
    cyc();
    b.i_dram_ack = 0;
    settle();
    check("wait_dram_req", b.o_dram_req, 0);
    check("wait_busy", b.o_busy, 1);
    b.i_dram_rvalid = 1; b.i_dram_rdata = LINE_D;
    cyc();
    b.i_dram_rvalid = 0;
    settle();
    check("fill_we", b.o_cache_we, 1);
    check("fill_waddr", b.o_cache_waddr, 28'h200);
    check("fill_wdata", b.o_cache_wdata, LINE_D);
    check("fill_rsp_valid", b.o_rsp_valid, 1);
    check("fill_rsp_inst", b.o_rsp_inst, 32'h1111_2222);
    cyc(); settle();
    check("miss_done_ready", b.o_req_ready, 1);
    check("miss_done_we", b.o_cache_we, 0);

    // stale refill: invalidate of the in-flight line during WAIT
    b.i_req_valid = 1; b.i_req_addr = 32'h2004;
    settle(); cyc();
    b.i_req_valid = 0; b.i_dram_ack = 1;
    cyc();
    b.i_dram_ack = 0; b.i_inv_valid = 1; b.i_inv_addr = 32'h200C;
    settle();
    check("stale_inv_ready", b.o_inv_ready, 1);
    cyc();
    b.i_inv_valid = 0; b.i_dram_rvalid = 1; b.i_dram_rdata = LINE_D;
    cyc();
    b.i_dram_rvalid = 0;
    settle();
    check("stale_fill_we", b.o_cache_we, 0);
    check("stale_fill_rsp", b.o_rsp_valid, 0);
    cyc(); settle();
    check("refetch_req", b.o_dram_req, 1);
    check("refetch_addr", b.o_dram_addr, 32'h2000);
    b.i_dram_ack = 1;
    cyc();
    b.i_dram_ack = 0; b.i_dram_rvalid = 1; b.i_dram_rdata = LINE_E;
    cyc();
    b.i_dram_rvalid = 0;
    settle();
    check("refill_we", b.o_cache_we, 1);
    check("refill_rsp_valid", b.o_rsp_valid, 1);
    check("refill_rsp_inst", b.o_rsp_inst, 32'hFEDC_BA98);
    check("refill_no_inv", b.o_cache_inv, 0);
    cyc(); settle();
    check("post_fill_inv", b.o_cache_inv, 1);
    check("post_fill_inv_index", b.o_cache_inv_index, 0);
    check("post_fill_inv_ready", b.o_req_ready, 0);
    cyc(); settle();
    check("inv_done", b.o_cache_inv, 0);
    check("inv_done_ready", b.o_req_ready, 1);

    // fence while 3 invalidates are queued behind a refill
    b.i_req_valid = 1; b.i_req_addr = 32'h3000;
    settle(); cyc();
    b.i_req_valid = 0;
    for (int k = 0; k < 3; k++) begin
      b.i_inv_valid = 1; b.i_inv_addr = 32'h4010 + k * 16;
      cyc();
    end
    b.i_inv_valid = 0; b.i_fence = 1;
    cyc();
    b.i_fence = 0;
    settle();
    check("fence_busy", b.o_busy, 1);
    check("fence_no_early_flush", b.o_cache_flush, 0);
    b.i_dram_ack = 1;
    cyc();
    b.i_dram_ack = 0; b.i_dram_rvalid = 1; b.i_dram_rdata = LINE_D;
    cyc();
    b.i_dram_rvalid = 0;
    settle();
    check("fence_stale_rsp", b.o_rsp_valid, 0);
    cyc();
    b.i_dram_ack = 1;
    cyc();
    b.i_dram_ack = 0; b.i_dram_rvalid = 1;
    cyc();
    b.i_dram_rvalid = 0;
    settle();
    check("fence_refill_rsp", b.o_rsp_valid, 1);
    check("fence_refill_inst", b.o_rsp_inst, 32'h3333_4444);
    cyc(); settle();
    check("fence_flush", b.o_cache_flush, 1);
    check("fence_done", b.o_fence_done, 1);
    check("fence_no_inv", b.o_cache_inv, 0);
    check("fence_req_ready", b.o_req_ready, 0);
    cyc(); settle();
    check("fence_flush_pulse", b.o_cache_flush, 0);
    check("fence_done_pulse", b.o_fence_done, 0);
    check("fence_fifo_dropped", b.o_cache_inv, 0);
    check("fence_idle_busy", b.o_busy, 0);
    b.i_req_valid = 1; b.i_req_addr = 32'h1000; b.i_cache_hit = 1; b.i_cache_rdata = LINE_H;
    settle();
    check("fence_next_ready", b.o_req_ready, 1);
    cyc();
    b.i_req_valid = 0; b.i_cache_hit = 0;
    settle();
    check("fence_next_rsp", b.o_rsp_valid, 1);
    check("fence_next_inst", b.o_rsp_inst, 32'h1111_1111);
    cyc();

    // FIFO full during a long REQ
    b.i_req_valid = 1; b.i_req_addr = 32'h5000;
    settle(); cyc();
    b.i_req_valid = 0;
    for (int k = 0; k < 4; k++) begin
      b.i_inv_valid = 1; b.i_inv_addr = 32'h6050 + k * 16;
      settle();
      check("full_push_ready", b.o_inv_ready, 1);
      cyc();
    end
    b.i_inv_addr = 32'h6090;
    settle();
    check("full_inv_ready", b.o_inv_ready, 0);
    check("full_still_req", b.o_dram_req, 1);
    cyc();
    b.i_inv_valid = 0; b.i_dram_ack = 1;
    cyc();
    b.i_dram_ack = 0; b.i_dram_rvalid = 1; b.i_dram_rdata = LINE_E;
    cyc();
    b.i_dram_rvalid = 0;
    settle();
    check("full_fill_we", b.o_cache_we, 1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      settle();
      check("drain_inv", b.o_cache_inv, 1);
      check("drain_index", b.o_cache_inv_index, 5 + k);
      check("drain_req_ready", b.o_req_ready, 0);
      cyc();
    end
    settle();
    check("drain_done_inv", b.o_cache_inv, 0);
    check("drain_done_ready", b.o_req_ready, 1);

    // ENABLED=0: hits are ignored and nothing is installed
    d.i_req_valid = 1; d.i_req_addr = 32'h1008; d.i_cache_hit = 1; d.i_cache_rdata = LINE_H;
    settle();
    check("dis_ready", d.o_req_ready, 1);
    cyc();
    d.i_req_valid = 0; d.i_cache_hit = 0;
    settle();
    check("dis_no_hit_rsp", d.o_rsp_valid, 0);
    check("dis_dram_req", d.o_dram_req, 1);
    check("dis_dram_addr", d.o_dram_addr, 32'h1000);
    d.i_dram_ack = 1;
    cyc();
    d.i_dram_ack = 0; d.i_dram_rvalid = 1; d.i_dram_rdata = LINE_D;
    cyc();
    d.i_dram_rvalid = 0;
    settle();
    check("dis_fill_we", d.o_cache_we, 0);
    check("dis_rsp_valid", d.o_rsp_valid, 1);
    check("dis_rsp_inst", d.o_rsp_inst, 32'hCCCC_DDDD);
    cyc();
    d.i_req_valid = 1; d.i_req_addr = 32'h7000;
    settle(); cyc();
    d.i_req_valid = 0; d.i_dram_ack = 1;
    cyc();
    d.i_dram_ack = 0;
    settle();
    check("dis_wait_busy", d.o_busy, 1);
    RST_D = 1;
    cyc();
    RST_D = 0;
    settle();
    check("dis_rst_busy", d.o_busy, 0);
    check("dis_rst_ready", d.o_req_ready, 1);
    d.i_dram_rvalid = 1; d.i_dram_rdata = LINE_D;
    cyc();
    d.i_dram_rvalid = 0;
    settle();
    check("dis_late_rsp", d.o_rsp_valid, 0);
    check("dis_late_we", d.o_cache_we, 0);
    check("dis_late_busy", d.o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
